// File: rtl/cmp_search_fsm.sv
// cmp_search_fsm: binary-search controller for a WIDTH-bit magnitude comparator.
// Drives the comparator's A operand (guess), samples its gt/eq/lt flags and
// narrows a [lo, hi] window until eq is seen or the window is exhausted.
// Optional feature: define CMP_SEARCH_CHECK_EN to flag non-one-hot comparator
// outputs through err; without it err is tied low and eq > gt > lt priority
// applies, with all-zero flags treated as lt.
module cmp_search_fsm #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              gt,
    input  logic              eq,
    input  logic              lt,
    output logic [WIDTH-1:0]  guess,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  found,
    output logic [STEP_W-1:0] steps,
    output logic              miss,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Window bounds carry one extra bit so lo can step past 2^WIDTH-1.
    localparam logic [WIDTH:0]   MAX_VAL  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MID_INIT = WIDTH'(MAX_VAL >> 1);

    state_t          state_reg;
    logic [WIDTH:0]  lo_reg;
    logic [WIDTH:0]  hi_reg;

    logic [WIDTH:0]   lo_next;
    logic [WIDTH:0]   hi_next;
    logic [WIDTH-1:0] guess_next;
    logic             exhausted;
    logic [WIDTH:0]   guess_ext;

    assign guess_ext = {1'b0, guess};

`ifdef CMP_SEARCH_CHECK_EN
    logic err_reg;
    logic flags_bad;

    // Exactly one of gt/eq/lt must be set for a sane comparator.
    assign flags_bad = ({gt, eq, lt} != 3'b100) &&
                       ({gt, eq, lt} != 3'b010) &&
                       ({gt, eq, lt} != 3'b001);
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Narrowed window and next midpoint for a non-eq evaluation; gt at guess 0
    // would underflow hi, so it is treated directly as an exhausted window.
    always_comb begin
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        exhausted  = 1'b0;
        if (gt) begin
            if (guess == '0) begin
                exhausted = 1'b1;
            end else begin
                hi_next = guess_ext - 1'b1;
            end
        end else begin
            lo_next = guess_ext + 1'b1;
        end
        if (lo_next > hi_next) begin
            exhausted = 1'b1;
        end
        guess_next = WIDTH'((lo_next + hi_next) >> 1);
    end

    // Search FSM with registered outputs; DONE holds results until restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            guess     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= '0;
            steps     <= '0;
            miss      <= 1'b0;
`ifdef CMP_SEARCH_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        lo_reg    <= '0;
                        hi_reg    <= MAX_VAL;
                        guess     <= MID_INIT;
                        steps     <= '0;
                        miss      <= 1'b0;
                        found     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef CMP_SEARCH_CHECK_EN
                        err_reg   <= 1'b0;
`endif
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Comparator settles on the freshly registered guess.
                    state_reg <= EVAL;
                end
                EVAL: begin
                    steps <= steps + 1'b1;
`ifdef CMP_SEARCH_CHECK_EN
                    if (flags_bad) begin
                        err_reg   <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end else
`endif
                    if (eq) begin
                        found     <= guess;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        lo_reg <= lo_next;
                        hi_reg <= hi_next;
                        if (exhausted) begin
                            miss      <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            guess     <= guess_next;
                            state_reg <= DRIVE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_search_fsm.sv
// Testbench for cmp_search_fsm: a behavioural comparator drives the flags from
// the DUT's guess and a hidden target (or a forced flag pattern), and a plain
// integer binary-search model predicts the guess sequence and final results.
module tb_cmp_search_fsm;
    localparam int WIDTH  = 3;
    localparam int STEP_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              gt, eq, lt;
    logic [WIDTH-1:0]  guess;
    logic              busy, done;
    logic [WIDTH-1:0]  found;
    logic [STEP_W-1:0] steps;
    logic              miss, err;

    int target;
    int fmode;   // 0 real comparator, 1 always gt, 2 always lt, 3 gt+eq, 4 none

    int n_checks = 0;
    int n_pass   = 0;

    // model results
    logic [WIDTH-1:0] exp_q[$];
    int               exp_steps;
    logic [WIDTH-1:0] exp_found;
    logic             exp_miss, exp_err;

    // observations from the last search
    int               obs_cycles;
    logic [WIDTH-1:0] obs_found;
    logic [STEP_W-1:0] obs_steps;
    logic             obs_miss, obs_err;

    cmp_search_fsm #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .guess (guess),
        .busy  (busy),
        .done  (done),
        .found (found),
        .steps (steps),
        .miss  (miss),
        .err   (err)
    );

    always #5 clk = ~clk;

    // behavioural comparator
    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        case (fmode)
            0: begin
                gt = (int'(guess) > target);
                eq = (int'(guess) == target);
                lt = (int'(guess) < target);
            end
            1: gt = 1'b1;
            2: lt = 1'b1;
            3: begin
                gt = 1'b1;
                eq = 1'b1;
            end
            default: ;
        endcase
    end

    // Reference: textbook binary search over [0, 2^WIDTH-1] with integer bounds.
    task automatic model_search(input int tgt, input int mode);
        int lo, hi, g, nflags;
        bit fg, fe, fl;
        lo = 0;
        hi = (1 << WIDTH) - 1;
        exp_q.delete();
        exp_steps = 0;
        exp_found = '0;
        exp_miss  = 1'b0;
        exp_err   = 1'b0;
        while (exp_steps <= WIDTH + 2) begin
            g = (lo + hi) / 2;
            exp_q.push_back(g[WIDTH-1:0]);
            exp_steps++;
            fg = 0; fe = 0; fl = 0;
            case (mode)
                0: begin fg = (g > tgt); fe = (g == tgt); fl = (g < tgt); end
                1: fg = 1;
                2: fl = 1;
                3: begin fg = 1; fe = 1; end
                default: ;
            endcase
            nflags = int'(fg) + int'(fe) + int'(fl);
`ifdef CMP_SEARCH_CHECK_EN
            if (nflags != 1) begin
                exp_err = 1'b1;
                break;
            end
`else
            if (nflags > 3) break;
`endif
            if (fe) begin
                exp_found = g[WIDTH-1:0];
                break;
            end
            if (fg) hi = g - 1;
            else    lo = g + 1;
            if (lo > hi) begin
                exp_miss = 1'b1;
                break;
            end
        end
    endtask

    // Full search scenario: pulse start, track the guess in each DRIVE cycle,
    // then check latency, results and guess sequence against the model.
    task automatic test_search(input int tgt, input int mode, input bit poke, input string nm);
        int cyc;
        bit busy_ok;
        bit seq_ok;
        logic [STEP_W-1:0] c1_steps;
        logic c1_done;
        logic [WIDTH-1:0] seq[$];
        model_search(tgt, mode);
        target = tgt;
        fmode  = mode;
        seq.delete();
        busy_ok  = 1;
        cyc      = 0;
        c1_steps = '1;
        c1_done  = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        forever begin
            @(posedge clk); cyc++; #1;
            if (cyc == 1) start = 1'b0;
            if (poke && cyc == 2) start = 1'b1;
            if (poke && cyc == 3) start = 1'b0;
            @(negedge clk);
            if (cyc == 1) begin
                c1_steps = steps;
                c1_done  = done;
            end
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 0;
            if (cyc % 2 == 1) seq.push_back(guess);
            if (cyc > 40) break;
        end
        start = 1'b0;
        obs_cycles = cyc;
        obs_found  = found;
        obs_steps  = steps;
        obs_miss   = miss;
        obs_err    = err;

        n_checks++;
        if (cyc != 2 * exp_steps + 1)
            $display("FAIL %s latency: got %0d cycles expected %0d", nm, cyc, 2 * exp_steps + 1);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", nm, busy);
        else n_pass++;
        n_checks++;
        if (!busy_ok) $display("FAIL %s busy_during_search: got 0 expected 1", nm);
        else n_pass++;
        n_checks++;
        if (int'(steps) != exp_steps) $display("FAIL %s steps: got %0d expected %0d", nm, steps, exp_steps);
        else n_pass++;
        n_checks++;
        if (found !== exp_found) $display("FAIL %s found: got %0d expected %0d", nm, found, exp_found);
        else n_pass++;
        n_checks++;
        if (miss !== exp_miss) $display("FAIL %s miss: got %b expected %b", nm, miss, exp_miss);
        else n_pass++;
        n_checks++;
        if (err !== exp_err) $display("FAIL %s err: got %b expected %b", nm, err, exp_err);
        else n_pass++;
        n_checks++;
        if (guess !== exp_q[exp_q.size()-1])
            $display("FAIL %s final_guess: got %0d expected %0d", nm, guess, exp_q[exp_q.size()-1]);
        else n_pass++;
        seq_ok = (seq.size() == exp_q.size());
        if (seq_ok) begin
            foreach (seq[i]) if (seq[i] !== exp_q[i]) seq_ok = 0;
        end
        n_checks++;
        if (!seq_ok) $display("FAIL %s guess_seq: got %p expected %p", nm, seq, exp_q);
        else n_pass++;
        n_checks++;
        if (c1_steps !== '0 || c1_done !== 1'b0)
            $display("FAIL %s restart_clear: got steps=%0d done=%b expected steps=0 done=0", nm, c1_steps, c1_done);
        else n_pass++;
        $display("search %s: target=%0d mode=%0d steps=%0d found=%0d miss=%b err=%b cycles=%0d",
                 nm, tgt, mode, steps, found, miss, err, cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({guess, busy, done, found, steps, miss, err} !== '0)
            $display("FAIL reset_state: got guess=%0d busy=%b done=%b found=%0d steps=%0d miss=%b err=%b expected all 0",
                     guess, busy, done, found, steps, miss, err);
        else n_pass++;
        // start together with rst: rst wins
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || guess !== '0)
            $display("FAIL reset_beats_start: got busy=%b guess=%0d expected busy=0 guess=0", busy, guess);
        else n_pass++;
        $display("reset: guess=%0d busy=%b done=%b", guess, busy, done);
    endtask

    task automatic test_directed();
        test_search(3, 0, 1'b0, "t3");
        n_checks++;
        if (obs_found !== 3'd3 || obs_steps !== 3'd1 || obs_cycles != 3)
            $display("FAIL t3_spec: got found=%0d steps=%0d cycles=%0d expected 3/1/3", obs_found, obs_steps, obs_cycles);
        else n_pass++;
        test_search(0, 0, 1'b0, "t0");
        n_checks++;
        if (obs_found !== 3'd0 || obs_steps !== 3'd3 || obs_miss !== 1'b0)
            $display("FAIL t0_spec: got found=%0d steps=%0d miss=%b expected 0/3/0", obs_found, obs_steps, obs_miss);
        else n_pass++;
        test_search(7, 0, 1'b0, "t7");
        n_checks++;
        if (obs_found !== 3'd7 || obs_steps !== 3'd4 || obs_cycles != 9)
            $display("FAIL t7_spec: got found=%0d steps=%0d cycles=%0d expected 7/4/9", obs_found, obs_steps, obs_cycles);
        else n_pass++;
    endtask

    task automatic test_miss();
        test_search(0, 1, 1'b0, "force_gt");
        n_checks++;
        if (obs_miss !== 1'b1 || obs_steps !== 3'd3)
            $display("FAIL force_gt_spec: got miss=%b steps=%0d expected 1/3", obs_miss, obs_steps);
        else n_pass++;
        test_search(0, 2, 1'b0, "force_lt");
        n_checks++;
        if (obs_miss !== 1'b1 || obs_steps !== 3'd4)
            $display("FAIL force_lt_spec: got miss=%b steps=%0d expected 1/4", obs_miss, obs_steps);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        target = 6;
        fmode  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;   // DRIVE
        @(posedge clk); #1 rst = 1'b1;     // EVAL
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({guess, busy, done, found, steps, miss, err} !== '0)
            $display("FAIL reset_mid: got guess=%0d busy=%b done=%b found=%0d steps=%0d miss=%b err=%b expected all 0",
                     guess, busy, done, found, steps, miss, err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_idle: got busy=%b done=%b expected 0/0", busy, done);
        else n_pass++;
        $display("reset_mid: guess=%0d busy=%b done=%b steps=%0d", guess, busy, done, steps);
        test_search(6, 0, 1'b0, "after_rst");
    endtask

    task automatic test_busy_start();
        test_search(2, 0, 1'b1, "poke_t2");
        test_search(5, 0, 1'b1, "poke_t5");
        test_search(3, 0, 1'b1, "poke_t3");
    endtask

    task automatic test_back_to_back();
        test_search(7, 0, 1'b0, "b2b_a");
        test_search(1, 0, 1'b0, "b2b_b");
        n_checks++;
        if (obs_steps !== 3'd2 || obs_found !== 3'd1)
            $display("FAIL b2b_restart: got steps=%0d found=%0d expected 2/1", obs_steps, obs_found);
        else n_pass++;
    endtask

    task automatic test_bad_flags();
        test_search(0, 3, 1'b0, "gt_eq");
`ifdef CMP_SEARCH_CHECK_EN
        n_checks++;
        if (obs_err !== 1'b1 || obs_steps !== 3'd1)
            $display("FAIL gt_eq_spec: got err=%b steps=%0d expected 1/1", obs_err, obs_steps);
        else n_pass++;
`else
        n_checks++;
        if (obs_found !== 3'd3 || obs_steps !== 3'd1 || obs_err !== 1'b0)
            $display("FAIL gt_eq_spec: got found=%0d steps=%0d err=%b expected 3/1/0", obs_found, obs_steps, obs_err);
        else n_pass++;
`endif
        test_search(0, 4, 1'b0, "no_flags");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            test_search(int'($urandom_range(0, 7)), 0, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        target = 0;
        fmode  = 0;
        test_reset();
        test_directed();
        test_miss();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        test_bad_flags();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
